// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_op_ctrl
// Brief    : Sequences TLB maintenance ops onto the TLB ports, one at a time,
//            and owns the free-running TLBFILL replacement index.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
    parameter int TLBNUM = 32,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      op_inv_op,
    input  logic [9:0]      op_inv_asid,
    input  logic [31:0]     op_inv_vaddr,
    input  logic [IDXW-1:0] op_index,
    output logic            tlb_we,
    output logic            tlb_fill_mode,
    output logic [IDXW-1:0] tlb_f_index,
    output logic [IDXW-1:0] tlb_r_index,
    output logic            tlb_check_mode,
    output logic            tlb_inv_en,
    output logic [2:0]      tlb_inv_op,
    output logic [9:0]      tlb_inv_asid,
    output logic [31:0]     tlb_inv_vaddr,
    input  logic            tlb_rs_e,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic            tlb_busy,
    output logic            done_valid,
    output logic            done_found,
    output logic [IDXW-1:0] done_index,
    output logic            done_err
);
    localparam logic [2:0]      c_op_srch    = 3'd1;
    localparam logic [2:0]      c_op_rd      = 3'd2;
    localparam logic [2:0]      c_op_wr      = 3'd3;
    localparam logic [2:0]      c_op_fill    = 3'd4;
    localparam logic [2:0]      c_op_inv     = 3'd5;
    localparam logic [4:0]      c_inv_op_max = 5'd6;
    localparam logic [IDXW-1:0] c_fill_last  = IDXW'(TLBNUM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_fill_cnt;
    logic [2:0]      r_op;
    logic            r_err;
    logic            w_accept;
    logic            w_illegal;
    logic            w_lookup;
    logic            w_modify;

    assign w_accept  = op_valid && (r_state == S_IDLE);
    assign w_illegal = (op_code == 3'd0) || (op_code > c_op_inv) ||
                       ((op_code == c_op_inv) && (op_inv_op > c_inv_op_max));
    assign w_lookup  = (r_op == c_op_srch) || (r_op == c_op_rd);
    assign w_modify  = !r_err && ((r_op == c_op_wr) || (r_op == c_op_fill) || (r_op == c_op_inv));

    // Replacement index: free-running, explicit wrap so non-power-of-2 sizes work
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill_cnt <= '0;
        end else if (r_fill_cnt == c_fill_last) begin
            r_fill_cnt <= '0;
        end else begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        op_ready       = 1'b0;
        tlb_we         = 1'b0;
        tlb_fill_mode  = 1'b0;
        tlb_inv_en     = 1'b0;
        tlb_check_mode = 1'b0;
        tlb_busy       = 1'b0;
        done_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_state_nxt = w_illegal ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                tlb_we         = (r_op == c_op_wr) || (r_op == c_op_fill);
                tlb_fill_mode  = (r_op == c_op_fill);
                tlb_inv_en     = (r_op == c_op_inv);
                tlb_check_mode = (r_op == c_op_srch);
                tlb_busy       = w_modify;
                w_state_nxt    = w_lookup ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                tlb_busy    = w_modify;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_valid     = 1'b1;
                tlb_check_mode = (r_op == c_op_srch) && !r_err;
                tlb_busy       = w_modify;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op          <= '0;
            r_err         <= 1'b0;
            tlb_r_index   <= '0;
            tlb_f_index   <= '0;
            tlb_inv_op    <= '0;
            tlb_inv_asid  <= '0;
            tlb_inv_vaddr <= '0;
            done_found    <= 1'b0;
            done_index    <= '0;
            done_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op          <= op_code;
                r_err         <= w_illegal;
                tlb_r_index   <= op_index;
                tlb_inv_op    <= op_inv_op[2:0];
                tlb_inv_asid  <= op_inv_asid;
                tlb_inv_vaddr <= op_inv_vaddr;
                if (op_code == c_op_fill) begin
                    tlb_f_index <= r_fill_cnt;
                end
            end
            // Only SRCH/RD go EXEC->DONE; only illegal requests go IDLE->DONE
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                done_found <= (r_state == S_EXEC) && tlb_rs_e;
                done_index <= (r_state == S_EXEC) ? tlb_s_index : '0;
                done_err   <= (r_state == S_IDLE);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_op_ctrl
// Brief    : Directed bench for tlb_op_ctrl with a per-cycle transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_op_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main DUT (TLBNUM = 32) ----------------
    logic        rstn;
    logic        op_valid, op_ready;
    logic [2:0]  op_code;
    logic [4:0]  op_inv_op;
    logic [9:0]  op_inv_asid;
    logic [31:0] op_inv_vaddr;
    logic [4:0]  op_index;
    logic        tlb_we, tlb_fill_mode, tlb_check_mode, tlb_inv_en, tlb_busy;
    logic [4:0]  tlb_f_index, tlb_r_index, tlb_s_index, done_index;
    logic [2:0]  tlb_inv_op;
    logic [9:0]  tlb_inv_asid;
    logic [31:0] tlb_inv_vaddr;
    logic        tlb_rs_e, done_valid, done_found, done_err;

    tlb_op_ctrl #(.TLBNUM(32)) dut (
        .clk(clk), .rstn(rstn),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_inv_op(op_inv_op), .op_inv_asid(op_inv_asid), .op_inv_vaddr(op_inv_vaddr),
        .op_index(op_index),
        .tlb_we(tlb_we), .tlb_fill_mode(tlb_fill_mode), .tlb_f_index(tlb_f_index),
        .tlb_r_index(tlb_r_index), .tlb_check_mode(tlb_check_mode),
        .tlb_inv_en(tlb_inv_en), .tlb_inv_op(tlb_inv_op), .tlb_inv_asid(tlb_inv_asid),
        .tlb_inv_vaddr(tlb_inv_vaddr), .tlb_rs_e(tlb_rs_e), .tlb_s_index(tlb_s_index),
        .tlb_busy(tlb_busy), .done_valid(done_valid), .done_found(done_found),
        .done_index(done_index), .done_err(done_err)
    );

    // ---------------- second DUT (TLBNUM = 24), FILL only ----------------
    logic        rst24_n;
    logic        op_valid_24, op_ready_24;
    logic [2:0]  op_code_24 = 3'd4;
    logic [4:0]  zero5 = '0;
    logic [9:0]  zero10 = '0;
    logic [31:0] zero32 = '0;
    logic        zero1 = 1'b0;
    logic        we_24, fm_24, cm_24, inv_en_24, busy_24, dv_24, df_24, de_24;
    logic [4:0]  f_idx_24, r_idx_24, di_24;
    logic [2:0]  inv_op_24;
    logic [9:0]  inv_asid_24;
    logic [31:0] inv_va_24;

    tlb_op_ctrl #(.TLBNUM(24)) dut24 (
        .clk(clk), .rstn(rst24_n),
        .op_valid(op_valid_24), .op_ready(op_ready_24), .op_code(op_code_24),
        .op_inv_op(zero5), .op_inv_asid(zero10), .op_inv_vaddr(zero32),
        .op_index(zero5),
        .tlb_we(we_24), .tlb_fill_mode(fm_24), .tlb_f_index(f_idx_24),
        .tlb_r_index(r_idx_24), .tlb_check_mode(cm_24),
        .tlb_inv_en(inv_en_24), .tlb_inv_op(inv_op_24), .tlb_inv_asid(inv_asid_24),
        .tlb_inv_vaddr(inv_va_24), .tlb_rs_e(zero1), .tlb_s_index(zero5),
        .tlb_busy(busy_24), .done_valid(dv_24), .done_found(df_24),
        .done_index(di_24), .done_err(de_24)
    );

    // ---------------- transaction model ----------------
    // One op in flight; its observable behaviour is a function of its age
    // (cycles since accept) and its latency.
    int m_active = 0, m_age = 0, m_lat = 0, m_kind = 0, m_illegal = 0;
    int m_cnt = 0, m_f = 0, m_r = 0, m_found = 0, m_dindex = 0;
    int m_invop = 0, m_asid = 0;
    logic [31:0] m_va = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 0; m_age = 0; m_cnt = 0; m_f = 0; m_r = 0;
            m_found = 0; m_dindex = 0; m_kind = 0; m_illegal = 0;
        end else begin
            if (m_active != 0) begin
                if (m_age == 1 && m_illegal == 0 && (m_kind == 1 || m_kind == 2)) begin
                    m_found  = int'(tlb_rs_e);
                    m_dindex = int'(tlb_s_index);
                end
                if (m_age == m_lat) m_active = 0;
                else m_age++;
            end else if (op_valid) begin
                m_active  = 1;
                m_age     = 1;
                m_kind    = int'(op_code);
                m_illegal = (m_kind == 0 || m_kind > 5 || (m_kind == 5 && int'(op_inv_op) > 6)) ? 1 : 0;
                m_lat     = (m_illegal != 0) ? 1 : ((m_kind <= 2) ? 2 : 3);
                m_r       = int'(op_index);
                if (m_kind == 4) m_f = m_cnt;
                m_invop   = int'(op_inv_op) % 8;
                m_asid    = int'(op_inv_asid);
                m_va      = op_inv_vaddr;
            end
            m_cnt = (m_cnt + 1) % 32;
        end
    end

    always @(negedge clk) begin
        int e_exec, e_done;
        e_exec = (m_active != 0 && m_age == 1 && m_illegal == 0) ? 1 : 0;
        e_done = (m_active != 0 && m_age == m_lat) ? 1 : 0;
        chk("op_ready",   32'(op_ready),       (m_active == 0) ? 1 : 0);
        chk("done_valid", 32'(done_valid),     e_done);
        chk("tlb_we",     32'(tlb_we),         (e_exec != 0 && (m_kind == 3 || m_kind == 4)) ? 1 : 0);
        chk("fill_mode",  32'(tlb_fill_mode),  (e_exec != 0 && m_kind == 4) ? 1 : 0);
        chk("inv_en",     32'(tlb_inv_en),     (e_exec != 0 && m_kind == 5) ? 1 : 0);
        chk("busy",       32'(tlb_busy),       (m_active != 0 && m_illegal == 0 && m_kind >= 3) ? 1 : 0);
        chk("check_mode", 32'(tlb_check_mode), (m_active != 0 && m_illegal == 0 && m_kind == 1) ? 1 : 0);
        chk("r_index",    32'(tlb_r_index),    m_r);
        chk("f_index",    32'(tlb_f_index),    m_f);
        if (e_exec != 0 && m_kind == 5) begin
            chk("inv_op",    32'(tlb_inv_op),   m_invop);
            chk("inv_asid",  32'(tlb_inv_asid), m_asid);
            chk("inv_vaddr", tlb_inv_vaddr,     m_va);
        end
        if (e_done != 0) begin
            chk("done_err", 32'(done_err), m_illegal);
            if (m_illegal == 0 && m_kind <= 2) begin
                chk("done_found", 32'(done_found), m_found);
                chk("done_index", 32'(done_index), m_dindex);
            end
        end
    end

    // Model for the 24-entry instance: only the fill index matters there.
    int m24_cnt = 0, m24_busy = 0, m24_f = 0;
    always @(posedge clk or negedge rst24_n) begin
        if (!rst24_n) begin
            m24_cnt = 0; m24_busy = 0; m24_f = 0;
        end else begin
            if (m24_busy > 0) m24_busy--;
            else if (op_valid_24) begin
                m24_f    = m24_cnt;
                m24_busy = 3;
            end
            m24_cnt = (m24_cnt + 1) % 24;
        end
    end

    always @(negedge clk) begin
        if (rst24_n) begin
            chk("f24_index", 32'(f_idx_24), m24_f);
            chk("f24_range", (f_idx_24 < 5'd24) ? 1 : 0, 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] code, input logic [4:0] idx, input logic [4:0] iop,
                         input logic [9:0] asid, input logic [31:0] va, input bit hold);
        int w = 0;
        op_valid = 1'b1; op_code = code; op_index = idx;
        op_inv_op = iop; op_inv_asid = asid; op_inv_vaddr = va;
        while (!op_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(op_ready), 1);
        @(negedge clk);
        if (!hold) op_valid = 1'b0;
    endtask

    // Called in the first cycle after accept; returns in the done cycle.
    task automatic observe(output int lat, output int we_n, output int inv_n, output int busy_n);
        lat = 1; we_n = int'(tlb_we); inv_n = int'(tlb_inv_en); busy_n = int'(tlb_busy);
        while (!done_valid && lat < 8) begin
            @(negedge clk);
            lat++;
            we_n += int'(tlb_we); inv_n += int'(tlb_inv_en); busy_n += int'(tlb_busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, we_n, inv_n, busy_n, cnt, dv_n;
        rstn = 1'b0; rst24_n = 1'b0; op_valid_24 = 1'b0;
        op_valid = 1'b0; op_code = '0; op_index = '0; op_inv_op = '0;
        op_inv_asid = '0; op_inv_vaddr = '0; tlb_rs_e = 1'b0; tlb_s_index = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(op_ready), 1);
        chk("reset_busy",  32'(tlb_busy), 0);
        rstn = 1'b1;

        // FILL after 7 idle cycles captures replacement index 7
        repeat (7) @(negedge clk);
        issue(3'd4, 5'd0, 5'd0, 10'd0, 32'd0, 1'b0);
        chk("fill_we_first",   32'(tlb_we),        1);
        chk("fill_mode_first", 32'(tlb_fill_mode), 1);
        chk("fill_index_7",    32'(tlb_f_index),   7);
        observe(lat, we_n, inv_n, busy_n);
        chk("fill_latency", lat, 3);
        chk("fill_we_count", we_n, 1);
        chk("fill_busy_count", busy_n, 3);

        // SRCH: hit result only valid during EXEC
        issue(3'd1, 5'd0, 5'd0, 10'd0, 32'd0, 1'b0);
        tlb_rs_e = 1'b1; tlb_s_index = 5'd13;
        chk("srch_busy_exec", 32'(tlb_busy), 0);
        chk("srch_dv_exec",   32'(done_valid), 0);
        @(negedge clk);
        tlb_rs_e = 1'b0; tlb_s_index = 5'd0;
        chk("srch_dv",     32'(done_valid), 1);
        chk("srch_found",  32'(done_found), 1);
        chk("srch_index",  32'(done_index), 13);
        chk("srch_busy",   32'(tlb_busy),   0);
        chk("srch_check",  32'(tlb_check_mode), 1);

        // RD with E=1
        issue(3'd2, 5'd9, 5'd0, 10'd0, 32'd0, 1'b0);
        tlb_rs_e = 1'b1; tlb_s_index = 5'd4;
        @(negedge clk);
        tlb_rs_e = 1'b0; tlb_s_index = 5'd0;
        chk("rd_found",  32'(done_found), 1);
        chk("rd_rindex", 32'(tlb_r_index), 9);

        // WR with op_valid held: back-to-back requests wait for IDLE
        issue(3'd3, 5'd5, 5'd0, 10'd0, 32'd0, 1'b1);
        op_index = 5'd11;
        chk("wr_rindex", 32'(tlb_r_index), 5);
        cnt = 0; we_n = 0;
        while (!op_ready && cnt < 8) begin
            cnt++;
            we_n += int'(tlb_we);
            @(negedge clk);
        end
        chk("wr_ready_low", cnt, 3);
        chk("wr_we_pulses", we_n, 1);
        chk("wr_rindex_held", 32'(tlb_r_index), 5);
        @(negedge clk);
        op_valid = 1'b0;
        chk("wr2_we", 32'(tlb_we), 1);
        chk("wr2_rindex", 32'(tlb_r_index), 11);
        observe(lat, we_n, inv_n, busy_n);
        chk("wr2_latency", lat, 3);

        // INV with illegal op field
        issue(3'd5, 5'd0, 5'd9, 10'h3FF, 32'hFFFF_0000, 1'b0);
        chk("inv9_dv",  32'(done_valid), 1);
        chk("inv9_err", 32'(done_err),   1);
        chk("inv9_en",  32'(tlb_inv_en), 0);
        chk("inv9_busy", 32'(tlb_busy),  0);

        // Legal INV
        issue(3'd5, 5'd0, 5'd5, 10'h2A, 32'h1234_5000, 1'b0);
        chk("inv5_en",   32'(tlb_inv_en),   1);
        chk("inv5_op",   32'(tlb_inv_op),   5);
        chk("inv5_asid", 32'(tlb_inv_asid), 32'h2A);
        observe(lat, we_n, inv_n, busy_n);
        chk("inv5_latency", lat, 3);
        chk("inv5_count", inv_n, 1);
        chk("inv5_we", we_n, 0);
        chk("inv5_err", 32'(done_err), 0);

        // Illegal opcode
        issue(3'd7, 5'd2, 5'd0, 10'd0, 32'd0, 1'b0);
        chk("op7_err", 32'(done_err), 1);
        chk("op7_we",  32'(tlb_we), 0);

        // Reset during SETTLE of a WR
        issue(3'd3, 5'd7, 5'd0, 10'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("settle_busy", 32'(tlb_busy), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_ready",  32'(op_ready),   1);
        chk("rst_busy",   32'(tlb_busy),   0);
        chk("rst_rindex", 32'(tlb_r_index), 0);
        chk("rst_dv",     32'(done_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        dv_n = 0;
        repeat (3) begin
            @(negedge clk);
            dv_n += int'(done_valid);
        end
        chk("rst_no_done", dv_n, 0);
        issue(3'd4, 5'd0, 5'd0, 10'd0, 32'd0, 1'b0);
        chk("rst_fill_index_3", 32'(tlb_f_index), 3);
        observe(lat, we_n, inv_n, busy_n);
        @(negedge clk);

        // 24-entry instance: replacement index wraps 23 -> 0
        @(negedge clk);
        rst24_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 3) op_valid_24 = 1'b1;
            if (i == 24) chk("f24_at_23", 32'(f_idx_24), 23);
            if (i == 28) chk("f24_wrapped", 32'(f_idx_24), 3);
        end
        op_valid_24 = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
